// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort window loader and its neighbours.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sort_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int NUM_VALS_D = 8;
    localparam int SIZE_D     = 8;

    // Width needed to hold an element count in the range 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sort_window_loader.sv
// Collects serial SIZE-bit samples into one packed NUM_VALS*SIZE frame for the descending sorter.
// Latency: frame presented the cycle after its last sample; sort_valid follows the handshake by one cycle.
// Backpressure: frame held stable with in_ready low until out_ready; short frames need SORT_LOADER_PAD_EN.
module sort_window_loader
    import sort_pkg::*;
#(
    parameter int  NUM_VALS  = NUM_VALS_D,
    parameter int  SIZE      = SIZE_D,
    parameter int  PAD_VALUE = 0,
    localparam int CW        = count_width(NUM_VALS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE-1:0]          in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_VALS*SIZE-1:0] out_data,
    output logic [CW-1:0]            out_count,
    output logic                     sort_valid
);

    localparam int              IW       = $clog2(NUM_VALS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_VALS - 1);
    localparam logic [SIZE-1:0] PAD_WORD = SIZE'(PAD_VALUE);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] idx;
    logic          last_slot;
    logic          accept;
    logic          short_frame;
    logic          close_frame;

`ifndef SORT_LOADER_PAD_EN
    // Without padding every frame is full length, so the frame marker and pad word go unused.
    logic [SIZE:0] unused_pad_cfg;
    assign unused_pad_cfg = {in_last, PAD_WORD};
`endif

    // State register; mid-frame reset drops back to filling from slot 0.
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs; handshakes depend only on the state register.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        short_frame = 1'b0;
        close_frame = 1'b0;
        last_slot   = (idx == LAST_IDX);
        case (state)
            FILL: begin
                in_ready = 1'b1;
                accept   = in_valid;
`ifdef SORT_LOADER_PAD_EN
                short_frame = in_valid && in_last && !last_slot;
`endif
                close_frame = in_valid && (last_slot || short_frame);
                if (close_frame) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // Slot writes, fill index and element count; slots are left intact after a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            out_data  <= '0;
            out_count <= '0;
        end else if (accept) begin
`ifdef SORT_LOADER_PAD_EN
            if (short_frame) begin
                for (int k = 0; k < NUM_VALS; k++) begin
                    if (IW'(k) > idx) out_data[SIZE*k +: SIZE] <= PAD_WORD;
                end
            end
`endif
            out_data[SIZE*idx +: SIZE] <= in_data;
            if (close_frame) begin
                idx       <= '0;
                out_count <= short_frame ? (CW'(idx) + CW'(1)) : CW'(NUM_VALS);
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Strobe lines up with the sorter's registered output of the frame just handed over.
    always_ff @(posedge clk) begin
        if (rst) sort_valid <= 1'b0;
        else     sort_valid <= out_valid && out_ready;
    end

endmodule

// File: tb/tb_sort_window_loader.sv
// Randomised self-checking bench for sort_window_loader against a frame-level reference model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: exercises held frames, ignored input during hold, and continuous streaming.
module tb_sort_window_loader;

    localparam int NV = 8;
    localparam int SZ = 8;
    localparam int CW = $clog2(NV + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SZ-1:0]    in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NV*SZ-1:0] out_data;
    logic [CW-1:0]    out_count;
    logic             sort_valid;

    int checks = 0;
    int errors = 0;

    sort_window_loader #(.NUM_VALS(NV), .SIZE(SZ), .PAD_VALUE(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .sort_valid(sort_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SZ-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference packing: element k of the frame occupies bits [SZ*k +: SZ].
    function automatic logic [NV*SZ-1:0] pack(input logic [SZ-1:0] s [NV]);
        logic [NV*SZ-1:0] v = '0;
        for (int k = 0; k < NV; k++) v[SZ*k +: SZ] = s[k];
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (sort_valid !== 1'b0) begin errors++; $display("FAIL reset_sort_valid got %b want 0", sort_valid); end
        checks++; if (out_count !== '0) begin errors++; $display("FAIL reset_out_count got %0d want 0", out_count); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_frame();
        logic [SZ-1:0] vals [NV] = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd0, 8'd5, 8'd2, 8'd8};
        logic [SZ-1:0] want_sorted [NV] = '{8'd9, 8'd8, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1, 8'd0};
        logic [SZ-1:0] q [$];
        logic [NV*SZ-1:0] captured;
        out_ready = 1'b1;
        for (int k = 0; k < NV; k++) begin
            send(vals[k], 1'b0);
            if (k == NV - 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %b want 0", out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_out_valid got %b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        checks++; if (out_data !== pack(vals)) begin errors++; $display("FAIL full_packing got %h want %h", out_data, pack(vals)); end
        checks++; if (out_count !== CW'(NV)) begin errors++; $display("FAIL full_count got %0d want %0d", out_count, NV); end
        captured = out_data;
        step();
        checks++; if (sort_valid !== 1'b1) begin errors++; $display("FAIL full_sort_valid got %b want 1", sort_valid); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_released got %b want 0", out_valid); end
        for (int k = 0; k < NV; k++) q.push_back(captured[SZ*k +: SZ]);
        q.rsort();
        for (int k = 0; k < NV; k++) begin
            checks++; if (q[k] !== want_sorted[k]) begin errors++; $display("FAIL full_sorted slot%0d got %0d want %0d", k, q[k], want_sorted[k]); end
        end
        out_ready = 1'b0;
        step();
        checks++; if (sort_valid !== 1'b0) begin errors++; $display("FAIL full_sort_pulse got %b want 0", sort_valid); end
    endtask

    task automatic test_backpressure();
        logic [SZ-1:0] vals [NV];
        for (int k = 0; k < NV; k++) vals[k] = SZ'($urandom);
        out_ready = 1'b0;
        for (int k = 0; k < NV; k++) send(vals[k], 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = SZ'($urandom);
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid c%0d got %b want 1", c, out_valid); end
            checks++; if (out_data !== pack(vals)) begin errors++; $display("FAIL bp_out_data c%0d got %h want %h", c, out_data, pack(vals)); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %b want 0", c, in_ready); end
            checks++; if (sort_valid !== 1'b0) begin errors++; $display("FAIL bp_sort_valid c%0d got %b want 0", c, sort_valid); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (sort_valid !== 1'b1) begin errors++; $display("FAIL bp_release_sort got %b want 1", sort_valid); end
        checks++; if (out_data !== pack(vals)) begin errors++; $display("FAIL bp_release_data got %h want %h", out_data, pack(vals)); end
        out_ready = 1'b0;
        step();
    endtask

    // With input and output always willing, each frame takes NV accept cycles plus one hold cycle.
    task automatic test_back_to_back();
        localparam int PERIOD = NV + 1;
        localparam int TOTAL  = 3 * PERIOD;
        logic [SZ-1:0] d [TOTAL];
        logic [SZ-1:0] frame [NV];
        for (int c = 0; c < TOTAL; c++) d[c] = SZ'($urandom);
        out_ready = 1'b1;
        for (int c = 0; c < TOTAL; c++) begin
            bit hold_cycle;
            hold_cycle = (c % PERIOD) == NV;
            in_valid = 1'b1;
            in_data  = d[c];
            checks++; if (out_valid !== hold_cycle) begin errors++; $display("FAIL b2b_out_valid c%0d got %b want %b", c, out_valid, hold_cycle); end
            checks++; if (in_ready !== !hold_cycle) begin errors++; $display("FAIL b2b_in_ready c%0d got %b want %b", c, in_ready, !hold_cycle); end
            checks++; if (sort_valid !== (c > 0 && (c % PERIOD) == 0)) begin errors++; $display("FAIL b2b_sort_valid c%0d got %b", c, sort_valid); end
            if (hold_cycle) begin
                for (int k = 0; k < NV; k++) frame[k] = d[c - NV + k];
                checks++; if (out_data !== pack(frame)) begin errors++; $display("FAIL b2b_frame c%0d got %h want %h", c, out_data, pack(frame)); end
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if (sort_valid !== 1'b1) begin errors++; $display("FAIL b2b_last_sort got %b want 1", sort_valid); end
        out_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic [SZ-1:0] vals [NV];
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(SZ'($urandom_range(100, 255)), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_data !== '0) begin errors++; $display("FAIL midrst_data got %h want 0", out_data); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        for (int k = 0; k < NV; k++) begin
            vals[k] = SZ'(10 + k);
            send(vals[k], 1'b0);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_frame_valid got %b want 1", out_valid); end
        checks++; if (out_data !== pack(vals)) begin errors++; $display("FAIL midrst_frame got %h want %h", out_data, pack(vals)); end
        checks++; if (out_count !== CW'(NV)) begin errors++; $display("FAIL midrst_count got %0d want %0d", out_count, NV); end
        out_ready = 1'b1;
        step();
        checks++; if (sort_valid !== 1'b1) begin errors++; $display("FAIL midrst_sort got %b want 1", sort_valid); end
        out_ready = 1'b0;
        step();
    endtask

`ifdef SORT_LOADER_PAD_EN
    task automatic test_pad();
        logic [SZ-1:0] vals [NV] = '{8'd6, 8'd4, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        logic [SZ-1:0] want_sorted [NV] = '{8'd9, 8'd6, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        logic [SZ-1:0] q [$];
        out_ready = 1'b0;
        send(8'd6, 1'b0);
        send(8'd4, 1'b0);
        send(8'd9, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pad_valid got %b want 1", out_valid); end
        checks++; if (out_count !== CW'(3)) begin errors++; $display("FAIL pad_count got %0d want 3", out_count); end
        checks++; if (out_data !== pack(vals)) begin errors++; $display("FAIL pad_frame got %h want %h", out_data, pack(vals)); end
        for (int k = 0; k < NV; k++) q.push_back(out_data[SZ*k +: SZ]);
        q.rsort();
        for (int k = 0; k < NV; k++) begin
            checks++; if (q[k] !== want_sorted[k]) begin errors++; $display("FAIL pad_sorted slot%0d got %0d want %0d", k, q[k], want_sorted[k]); end
        end
        out_ready = 1'b1;
        step();
        checks++; if (sort_valid !== 1'b1) begin errors++; $display("FAIL pad_sort got %b want 1", sort_valid); end
        out_ready = 1'b0;
        step();
    endtask
`else
    task automatic test_last_ignored();
        send(8'd6, 1'b0);
        send(8'd4, 1'b0);
        send(8'd9, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL last_ignored_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL last_ignored_ready got %b want 1", in_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SORT_LOADER_PAD_EN
        test_pad();
`else
        test_last_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
